pwr_seq_ctrl: RTL and testbench

Power-rail sequencer for the PDB CPLD, timed by the 1 ms tick enable from the clock-generator block.
- Power-up: enables NUM_RAILS rails in ascending order. Each rail must report power-good within a timeout, then a settle delay runs before the next rail is enabled.
- Power-down: disables rails in descending order with a fixed inter-rail delay.
- Monitoring: watches power-good of every enabled rail and latches a fault.
- Outputs: rail enables and status, consumed by the board control and status-register logic.

---
 rtl/pwr_seq_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_pwr_seq_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwr_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pwr_seq_ctrl
//  Description : Power-rail sequencer for the PDB CPLD. Brings NUM_RAILS
//                regulators up in ascending order. Each rail must report
//                power-good within a timeout, and then a settle delay runs.
//                Rails are brought down in descending order with a fixed
//                inter-rail delay. While sequencing or running, the
//                power-good of every enabled rail is watched, and a fault is
//                latched on the first loss. All timing is in ms, driven by
//                the 1 ms tick enable from the clock generator.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   system clock (2 MHz)
//    nrst           in   asynchronous active-low reset
//    tick_1ms_en_i  in   one-clk pulse every 1 ms
//    pwr_on_req_i   in   level: 1 = power up / stay on, 0 = power down
//    fault_clr_i    in   one-clk pulse, clears a latched fault (only when
//                        pwr_on_req_i = 0)
//    rail_pg_i      in   asynchronous power-good per rail
//    rail_en_o      out  registered regulator enables
//    pwr_ok_o       out  high only while all rails are up (RUN)
//    fault_o        out  latched fault flag
//    fault_rail_o   out  one-hot rail that caused the fault, latched
//    seq_state_o    out  state code: IDLE=0 PG_WAIT=1 DELAY=2 RUN=3 OFF=4
//                        FAULT=5
// ============================================================================
module pwr_seq_ctrl #(
    parameter int               NUM_RAILS  = 4,
    parameter int               CNT_W      = 8,
    parameter logic [CNT_W-1:0] PG_TMO_MS  = CNT_W'(50),
    parameter logic [CNT_W-1:0] ON_DLY_MS  = CNT_W'(10),
    parameter logic [CNT_W-1:0] OFF_DLY_MS = CNT_W'(5)
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 tick_1ms_en_i,
    input  logic                 pwr_on_req_i,
    input  logic                 fault_clr_i,
    input  logic [NUM_RAILS-1:0] rail_pg_i,
    output logic [NUM_RAILS-1:0] rail_en_o,
    output logic                 pwr_ok_o,
    output logic                 fault_o,
    output logic [NUM_RAILS-1:0] fault_rail_o,
    output logic [2:0]           seq_state_o
);

    localparam int                   IDX_W    = (NUM_RAILS > 2) ? $clog2(NUM_RAILS) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_RAILS - 1);
    localparam logic [NUM_RAILS-1:0] RAIL0_OH = NUM_RAILS'(1);
    localparam logic [CNT_W-1:0]     CNT_MAX  = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PG_WAIT = 3'd1,
        ST_DELAY   = 3'd2,
        ST_RUN     = 3'd3,
        ST_OFF     = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_t               state_q,      state_d;
    logic [IDX_W-1:0]     idx_q,        idx_d;
    logic [CNT_W-1:0]     cnt_q,        cnt_d;
    logic [NUM_RAILS-1:0] rail_en_q,    rail_en_d;
    logic                 fault_q,      fault_d;
    logic [NUM_RAILS-1:0] fault_rail_q, fault_rail_d;
    logic                 pwr_ok_q,     pwr_ok_d;

    // Two-flop synchroniser for the asynchronous power-good inputs.
    logic [NUM_RAILS-1:0] pg_meta_q;
    logic [NUM_RAILS-1:0] pg_s_q;

    // ------------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------------
    logic [NUM_RAILS-1:0] w_idx_oh;
    logic                 w_pg_cur;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic                 w_tmo_hit;
    logic                 w_on_done;
    logic                 w_off_done;
    logic [NUM_RAILS-1:0] w_mon_bad;
    logic [NUM_RAILS-1:0] w_wait_bad;

    // Rail selection is done through a one-hot mask so that an index value
    // beyond NUM_RAILS-1 (possible for non power-of-two rail counts) can
    // never address a non-existent bit.
    assign w_idx_oh  = RAIL0_OH << idx_q;
    assign w_pg_cur  = |(pg_s_q & w_idx_oh);

    // A delay of N ms completes on the tick that makes the counter equal N.
    assign w_cnt_inc  = cnt_q + CNT_W'(1);
    assign w_tmo_hit  = tick_1ms_en_i && (w_cnt_inc == PG_TMO_MS);
    assign w_on_done  = tick_1ms_en_i && (w_cnt_inc == ON_DLY_MS);
    assign w_off_done = tick_1ms_en_i && (w_cnt_inc == OFF_DLY_MS);

    // Enabled rails that have lost power-good.
    assign w_mon_bad  = rail_en_q & ~pg_s_q;

    // While waiting on the current rail it is exempt from monitoring, but it
    // becomes a fault source itself on timeout. A timeout tick coinciding
    // with its power-good arriving is treated as success.
    assign w_wait_bad = (w_mon_bad & ~w_idx_oh)
                      | ((w_tmo_hit && !w_pg_cur) ? w_idx_oh : '0);

    // Isolate the lowest set bit (two's-complement trick).
    function automatic logic [NUM_RAILS-1:0] lowest_oh(input logic [NUM_RAILS-1:0] v);
        return v & (~v + RAIL0_OH);
    endfunction

    // ------------------------------------------------------------------------
    // Next-state logic. Priority within each state is:
    //   fault condition > pwr_on_req_i low > sequencing progress.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rail_en_d    = rail_en_q;
        fault_d      = fault_q;
        fault_rail_d = fault_rail_q;

        case (state_q)
            ST_IDLE: begin
                rail_en_d = '0;
                if (pwr_on_req_i && !fault_q) begin
                    state_d   = ST_PG_WAIT;
                    idx_d     = '0;
                    rail_en_d = RAIL0_OH;
                end
            end

            ST_PG_WAIT: begin
                if (|w_wait_bad) begin
                    state_d      = ST_FAULT;
                    rail_en_d    = '0;
                    fault_d      = 1'b1;
                    fault_rail_d = lowest_oh(w_wait_bad);
                end else if (!pwr_on_req_i) begin
                    // Abort: drop the rail being waited on, then unwind.
                    state_d   = ST_OFF;
                    rail_en_d = rail_en_q & ~w_idx_oh;
                end else if (w_pg_cur) begin
                    state_d = ST_DELAY;
                end
            end

            ST_DELAY: begin
                if (|w_mon_bad) begin
                    state_d      = ST_FAULT;
                    rail_en_d    = '0;
                    fault_d      = 1'b1;
                    fault_rail_d = lowest_oh(w_mon_bad);
                end else if (!pwr_on_req_i) begin
                    state_d   = ST_OFF;
                    rail_en_d = rail_en_q & ~w_idx_oh;
                end else if (w_on_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d   = ST_PG_WAIT;
                        idx_d     = idx_q + IDX_W'(1);
                        rail_en_d = rail_en_q | (w_idx_oh << 1);
                    end
                end
            end

            ST_RUN: begin
                if (|w_mon_bad) begin
                    state_d      = ST_FAULT;
                    rail_en_d    = '0;
                    fault_d      = 1'b1;
                    fault_rail_d = lowest_oh(w_mon_bad);
                end else if (!pwr_on_req_i) begin
                    // idx already points at the top rail.
                    state_d   = ST_OFF;
                    rail_en_d = rail_en_q & ~w_idx_oh;
                end
            end

            ST_OFF: begin
                // Power-good is not monitored and a renewed power request is
                // not honoured until the unwind reaches IDLE.
                if (w_off_done) begin
                    if (idx_q != '0) begin
                        idx_d     = idx_q - IDX_W'(1);
                        rail_en_d = rail_en_q & ~(w_idx_oh >> 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_FAULT: begin
                rail_en_d = '0;
                // Clearing is only accepted once the host has withdrawn the
                // power request, so a fault cannot immediately re-sequence.
                if (fault_clr_i && !pwr_on_req_i) begin
                    state_d      = ST_IDLE;
                    fault_d      = 1'b0;
                    fault_rail_d = '0;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                idx_d     = '0;
                rail_en_d = '0;
            end
        endcase

        // The ms counter restarts on every state or rail-index change and
        // saturates so that long stays in RUN/IDLE cannot wrap it.
        if ((state_d != state_q) || (idx_d != idx_q)) begin
            cnt_d = '0;
        end else if (tick_1ms_en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = w_cnt_inc;
        end else begin
            cnt_d = cnt_q;
        end

        pwr_ok_d = (state_d == ST_RUN);
    end

    // ------------------------------------------------------------------------
    // Registers. Reset drops every enable asynchronously.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            rail_en_q    <= '0;
            fault_q      <= 1'b0;
            fault_rail_q <= '0;
            pwr_ok_q     <= 1'b0;
            pg_meta_q    <= '0;
            pg_s_q       <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            rail_en_q    <= rail_en_d;
            fault_q      <= fault_d;
            fault_rail_q <= fault_rail_d;
            pwr_ok_q     <= pwr_ok_d;
            pg_meta_q    <= rail_pg_i;
            pg_s_q       <= pg_meta_q;
        end
    end

    assign rail_en_o    = rail_en_q;
    assign pwr_ok_o     = pwr_ok_q;
    assign fault_o      = fault_q;
    assign fault_rail_o = fault_rail_q;
    assign seq_state_o  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pwr_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwr_seq_ctrl
//  Description : Self-checking bench for pwr_seq_ctrl. A regulator
//                environment answers each enable with power-good three ticks
//                later. A behavioural model tracks enabled rails as a
//                contiguous count and predicts every output each cycle.
//                Directed scenarios add literal expectations on top.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwr_seq_ctrl;

    localparam int N       = 4;
    localparam int TMO     = 50;
    localparam int ON_DLY  = 10;
    localparam int OFF_DLY = 5;

    logic         clk;
    logic         nrst;
    logic         tick_1ms_en;
    logic         pwr_on_req;
    logic         fault_clr;
    logic [N-1:0] rail_pg;
    logic [N-1:0] rail_en;
    logic         pwr_ok;
    logic         fault;
    logic [N-1:0] fault_rail;
    logic [2:0]   seq_state;

    pwr_seq_ctrl #(
        .NUM_RAILS  (N),
        .CNT_W      (8),
        .PG_TMO_MS  (8'd50),
        .ON_DLY_MS  (8'd10),
        .OFF_DLY_MS (8'd5)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .tick_1ms_en_i (tick_1ms_en),
        .pwr_on_req_i  (pwr_on_req),
        .fault_clr_i   (fault_clr),
        .rail_pg_i     (rail_pg),
        .rail_en_o     (rail_en),
        .pwr_ok_o      (pwr_ok),
        .fault_o       (fault),
        .fault_rail_o  (fault_rail),
        .seq_state_o   (seq_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Regulator environment: tick every 4 clk, pg 3 ticks after enable.
    // Updated 2 time units after each rising edge. Also records every change
    // of rail_en with the number of ticks since the previous change.
    // ------------------------------------------------------------------------
    logic [N-1:0] pg_r;
    logic [N-1:0] stuck;
    logic [N-1:0] glitch;
    logic [N-1:0] prev_en;
    logic         prev_ok;
    int           phase;
    int           gap;
    int           tcnt[N];
    int           since_pg[N];
    int           up_gap[N];
    int           ok_gap;
    int           chg_val[$];
    int           chg_gap[$];

    initial begin
        tick_1ms_en = 1'b0;
        rail_pg     = '0;
        pg_r        = '0;
        stuck       = '0;
        glitch      = '0;
        prev_en     = '0;
        prev_ok     = 1'b0;
        phase       = 0;
        gap         = 0;
        ok_gap      = -1;
        for (int i = 0; i < N; i++) begin
            tcnt[i]     = 0;
            since_pg[i] = 0;
            up_gap[i]   = -1;
        end
        forever begin
            @(posedge clk);
            #2;
            if (rail_en !== prev_en) begin
                for (int i = 1; i < N; i++)
                    if (rail_en[i] && !prev_en[i]) up_gap[i] = since_pg[i-1];
                chg_val.push_back(int'(rail_en));
                chg_gap.push_back(gap);
                gap     = 0;
                prev_en = rail_en;
            end
            if (pwr_ok && !prev_ok) ok_gap = since_pg[N-1];
            prev_ok = pwr_ok;
            phase       = (phase + 1) % 4;
            tick_1ms_en = (phase == 0);
            if (tick_1ms_en) begin
                gap++;
                for (int i = 0; i < N; i++) begin
                    since_pg[i]++;
                    if (rail_en[i] && !pg_r[i]) tcnt[i]++;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!rail_en[i]) begin
                    pg_r[i] = 1'b0;
                    tcnt[i] = 0;
                end else if (!pg_r[i] && !stuck[i] && tcnt[i] >= 3) begin
                    pg_r[i]     = 1'b1;
                    since_pg[i] = 0;
                end
            end
            rail_pg = pg_r & ~glitch;
        end
    end

    // ------------------------------------------------------------------------
    // Behavioural model. Enabled rails are always a contiguous block from
    // rail 0, so they are held as a count (m_nup). Mode codes equal the
    // published seq_state codes.
    // ------------------------------------------------------------------------
    int           m_mode;
    int           m_idx;
    int           m_ms;
    int           m_nup;
    bit           m_fault;
    logic [N-1:0] m_frail;
    logic [N-1:0] p1;
    logic [N-1:0] p2;

    function automatic logic [N-1:0] first_bit(input logic [N-1:0] b);
        for (int j = 0; j < N; j++)
            if (b[j]) return N'(1) << j;
        return '0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_ms = 0; m_nup = 0;
        m_fault = 1'b0; m_frail = '0; p1 = '0; p2 = '0;
    endtask

    task automatic model_trip(input logic [N-1:0] bad);
        m_nup   = 0;
        m_fault = 1'b1;
        m_frail = first_bit(bad);
    endtask

    task automatic model_step();
        logic [N-1:0] pgs, en, me, bad;
        int nmode, nidx;
        pgs   = p2;
        p2    = p1;
        p1    = rail_pg;
        en    = N'((1 << m_nup) - 1);
        me    = N'(1 << m_idx);
        nmode = m_mode;
        nidx  = m_idx;
        case (m_mode)
            0: if (pwr_on_req && !m_fault) begin nmode = 1; nidx = 0; m_nup = 1; end
            1: begin
                bad = en & ~pgs & ~me;
                if (tick_1ms_en && (m_ms + 1 == TMO) && ((pgs & me) == '0)) bad = bad | me;
                if (bad != '0) begin nmode = 5; model_trip(bad); end
                else if (!pwr_on_req) begin nmode = 4; m_nup = m_idx; end
                else if ((pgs & me) != '0) nmode = 2;
            end
            2: begin
                bad = en & ~pgs;
                if (bad != '0) begin nmode = 5; model_trip(bad); end
                else if (!pwr_on_req) begin nmode = 4; m_nup = m_idx; end
                else if (tick_1ms_en && (m_ms + 1 == ON_DLY)) begin
                    if (m_idx == N - 1) nmode = 3;
                    else begin nmode = 1; nidx = m_idx + 1; m_nup = nidx + 1; end
                end
            end
            3: begin
                bad = en & ~pgs;
                if (bad != '0) begin nmode = 5; model_trip(bad); end
                else if (!pwr_on_req) begin nmode = 4; m_nup = m_idx; end
            end
            4: if (tick_1ms_en && (m_ms + 1 == OFF_DLY)) begin
                if (m_idx > 0) begin nidx = m_idx - 1; m_nup = nidx; end
                else nmode = 0;
            end
            5: if (fault_clr && !pwr_on_req) begin nmode = 0; m_fault = 1'b0; m_frail = '0; end
            default: nmode = 0;
        endcase
        if (nmode != m_mode || nidx != m_idx) m_ms = 0;
        else if (tick_1ms_en) m_ms++;
        m_mode = nmode;
        m_idx  = nidx;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge nrst);
            if (!nrst) model_reset();
            else       model_step();
        end
    end

    // Per-cycle comparison against the model: {state, pwr_ok, fault, fault_rail, rail_en}.
    initial begin
        logic [12:0] act_v, exp_v;
        forever begin
            @(posedge clk);
            #1;
            if (nrst === 1'b1) begin
                exp_v = {3'(m_mode), (m_mode == 3), m_fault, m_frail, N'((1 << m_nup) - 1)};
                act_v = {seq_state, pwr_ok, fault, fault_rail, rail_en};
                chk("model", int'(act_v), int'(exp_v));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------------
    task automatic wait_state(input int s, input int budget, input string name);
        int k = 0;
        while (int'(seq_state) != s && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, int'(seq_state), s);
    endtask

    task automatic chk_seq4(input string name, input int v0, input int v1, input int v2, input int v3);
        int e[4];
        e = '{v0, v1, v2, v3};
        chk({name, "_len"}, chg_val.size(), 4);
        for (int i = 0; i < 4 && i < chg_val.size(); i++) chk({name, "_val"}, chg_val[i], e[i]);
    endtask

    task automatic clear_fault();
        @(negedge clk) pwr_on_req = 1'b0;
        @(negedge clk) fault_clr  = 1'b1;
        @(negedge clk) fault_clr  = 1'b0;
    endtask

    initial begin
        nrst       = 1'b0;
        pwr_on_req = 1'b0;
        fault_clr  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_en",    int'(rail_en), 0);
        chk("rst_ok",    int'(pwr_ok), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_frail", int'(fault_rail), 0);
        chk("rst_state", int'(seq_state), 0);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // Normal power-up
        chg_val.delete(); chg_gap.delete();
        pwr_on_req = 1'b1;
        wait_state(3, 1000, "up_run");
        chk_seq4("up_steps", 1, 3, 7, 15);
        for (int i = 1; i < N; i++) chk("up_settle_ticks", up_gap[i], ON_DLY);
        chk("run_settle_ticks", ok_gap, ON_DLY);
        chk("up_ok",    int'(pwr_ok), 1);
        chk("up_fault", int'(fault), 0);

        // Normal power-down from RUN
        @(negedge clk);
        chg_val.delete(); chg_gap.delete();
        pwr_on_req = 1'b0;
        @(posedge clk); #1;
        chk("dn_state", int'(seq_state), 4);
        chk("dn_ok",    int'(pwr_ok), 0);
        chk("dn_en",    int'(rail_en), 7);
        wait_state(0, 1000, "dn_idle");
        chk_seq4("dn_steps", 7, 3, 1, 0);
        for (int i = 1; i < 4 && i < chg_gap.size(); i++) chk("dn_gap_ticks", chg_gap[i], OFF_DLY);

        // Abort during DELAY of rail 1
        @(negedge clk);
        pwr_on_req = 1'b1;
        for (int k = 0; k < 1000 && !(seq_state == 3'd2 && rail_en == 4'b0011); k++) @(negedge clk);
        chk("ab_delay1", int'(rail_en), 3);
        chg_val.delete(); chg_gap.delete();
        pwr_on_req = 1'b0;
        @(posedge clk); #1;
        chk("ab_state", int'(seq_state), 4);
        chk("ab_en",    int'(rail_en), 1);
        wait_state(0, 1000, "ab_idle");
        chk("ab_len", chg_val.size(), 2);
        if (chg_val.size() >= 2) begin
            chk("ab_last", chg_val[1], 0);
            chk("ab_gap",  chg_gap[1], OFF_DLY);
        end
        chk("ab_fault", int'(fault), 0);

        // PG timeout on rail 2
        @(negedge clk);
        stuck = 4'b0100;
        chg_val.delete(); chg_gap.delete();
        pwr_on_req = 1'b1;
        wait_state(5, 2000, "tmo_fault_state");
        chk_seq4("tmo_steps", 1, 3, 7, 0);
        if (chg_gap.size() >= 4) chk("tmo_ticks", chg_gap[3], TMO);
        chk("tmo_fault", int'(fault), 1);
        chk("tmo_frail", int'(fault_rail), 4);
        @(negedge clk) fault_clr = 1'b1;
        @(negedge clk) fault_clr = 1'b0;
        chk("tmo_clr_ignored", int'(seq_state), 5);
        chk("tmo_clr_ign_flt", int'(fault), 1);
        clear_fault();
        chk("tmo_clr_state", int'(seq_state), 0);
        chk("tmo_clr_fault", int'(fault), 0);
        chk("tmo_clr_frail", int'(fault_rail), 0);
        stuck = '0;

        // RUN brownout on rail 1
        @(negedge clk) pwr_on_req = 1'b1;
        wait_state(3, 1000, "bo_run");
        @(negedge clk) glitch = 4'b0010;
        @(negedge clk) glitch = '0;
        for (int k = 0; k < 3 && !fault; k++) begin @(posedge clk); #1; end
        chk("bo_fault", int'(fault), 1);
        chk("bo_frail", int'(fault_rail), 2);
        chk("bo_en",    int'(rail_en), 0);
        clear_fault();

        // Brownout seen in the same cycle as pwr_on_req falling
        @(negedge clk) pwr_on_req = 1'b1;
        wait_state(3, 1000, "bo2_run");
        @(negedge clk) glitch = 4'b0010;
        @(negedge clk) glitch = '0;
        @(negedge clk);
        @(negedge clk) pwr_on_req = 1'b0;
        @(posedge clk); #1;
        chk("bo2_state", int'(seq_state), 5);
        chk("bo2_frail", int'(fault_rail), 2);
        clear_fault();

        // Asynchronous reset in RUN
        @(negedge clk) pwr_on_req = 1'b1;
        wait_state(3, 1000, "ar_run");
        @(negedge clk);
        #3 nrst = 1'b0;
        #1;
        chk("ar_en",    int'(rail_en), 0);
        chk("ar_ok",    int'(pwr_ok), 0);
        chk("ar_state", int'(seq_state), 0);
        @(negedge clk) nrst = 1'b1;
        @(posedge clk); #1;
        chk("ar_restart_state", int'(seq_state), 1);
        chk("ar_restart_en",    int'(rail_en), 1);
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
